// File: rtl/alu_seq.sv
// alu_seq: registered single-cycle ALU with an iterative signed 32x32 multiplier.
// Single-cycle ops complete on the accept edge. mult takes 32 further edges,
// processing one multiplier bit per edge, and then returns to IDLE.
module alu_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic [31:0] hi_o,
    output logic        zero_o,
    output logic        ovf_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_LUI  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRLV = 4'b1111;

    logic [0:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic [31:0] hi_q, hi_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [31:0] sum, diff, aluRes;
    logic        aluOvf;
    logic [63:0] partial, accSum;

    // Single-cycle ALU datapath; overflow only meaningful for add/sub.
    always_comb begin
        sum    = src1_i + src2_i;
        diff   = src1_i - src2_i;
        aluRes = 32'd0;
        aluOvf = 1'b0;
        case (ctrl_i)
            OP_AND:  aluRes = src1_i & src2_i;
            OP_OR:   aluRes = src1_i | src2_i;
            OP_ADD: begin
                aluRes = sum;
                aluOvf = (src1_i[31] == src2_i[31]) && (sum[31] != src1_i[31]);
            end
            OP_SUB: begin
                aluRes = diff;
                aluOvf = (src1_i[31] != src2_i[31]) && (diff[31] != src1_i[31]);
            end
            OP_SLT:  aluRes = {31'd0, ($signed(src1_i) < $signed(src2_i))};
            OP_SLL:  aluRes = src2_i << shamt_i;
            OP_SRLV: aluRes = src2_i >> src1_i[4:0];
            OP_LUI:  aluRes = {src2_i[15:0], 16'd0};
            default: aluRes = 32'd0;
        endcase
    end

    // Shift-add step: the multiplier's sign bit (last step) carries weight -2^31,
    // so the shifted multiplicand is subtracted instead of added on that step.
    always_comb begin
        partial = 64'd0;
        if (mplier_q[0]) begin
            partial = (cnt_q == 5'd31) ? (~mcand_q + 64'd1) : mcand_q;
        end
        accSum = acc_q + partial;
    end

    // Next-state logic: accept in IDLE, iterate in MUL, finish after 32 steps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (ctrl_i == OP_MULT) begin
                        state_d  = MUL;
                        mcand_d  = {{32{src1_i[31]}}, src1_i};
                        mplier_d = src2_i;
                        acc_d    = 64'd0;
                        cnt_d    = 5'd0;
                    end else begin
                        result_d = aluRes;
                        zero_d   = (aluRes == 32'd0);
                        ovf_d    = aluOvf;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = accSum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = IDLE;
                    cnt_d    = 5'd0;
                    result_d = accSum[31:0];
                    hi_d     = accSum[63:32];
                    zero_d   = (accSum[31:0] == 32'd0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any multiply without a done pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            hi_q     <= 32'd0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;
    assign busy_o   = (state_q == MUL);
    assign done_o   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed vectors feed a scoreboard queue; a monitor
// pops and compares on every done_o pulse.
module tb_alu_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic        zero_o;
    logic        ovf_o;
    logic        busy_o;
    logic        done_o;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   doneCount  = 0;

    alu_seq dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .result_o (result_o),
        .hi_o     (hi_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    // 10-unit clock period
    always #5 clk_i = ~clk_i;

    // Shared comparison helper: bumps counters and reports any mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one request for exactly one rising edge and optionally queues its result
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input bit expectDone,
                                 input logic [31:0] eRes, input logic [31:0] eHi,
                                 input logic eZero, input logic eOvf);
        exp_t e;
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
        if (expectDone) begin
            e.res  = eRes;
            e.hi   = eHi;
            e.zero = eZero;
            e.ovf  = eOvf;
            sb.push_back(e);
        end
    endtask

    // Drops start and waits n cycles
    task automatic idle(input int n);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    // Issues a mult and measures how many cycles busy_o stays high
    task automatic runMul(input logic [31:0] a, input logic [31:0] b, input bit holdStart,
                          input bit changeOps, input logic [31:0] eRes, input logic [31:0] eHi,
                          input logic eZero);
        int busyCycles;
        applyStimulus(4'b0011, a, b, 5'd0, 1'b1, eRes, eHi, eZero, 1'b0);
        @(negedge clk_i);
        start_i    = holdStart;
        busyCycles = 0;
        while (busy_o && busyCycles < 100) begin
            busyCycles++;
            if (changeOps) begin
                src1_i = $urandom;
                src2_i = $urandom;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        checkOutput("mult busy cycles", 64'(busyCycles), 64'd32);
    endtask

    // Monitor: every done_o pulse must match the oldest queued expectation
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (done_o) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected done_o", 64'(done_o), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("result_o", 64'(result_o), 64'(e.res));
                checkOutput("hi_o",     64'(hi_o),     64'(e.hi));
                checkOutput("zero_o",   64'(zero_o),   64'(e.zero));
                checkOutput("ovf_o",    64'(ovf_o),    64'(e.ovf));
            end
        end
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        int doneBefore;
        rst_i   = 1'b0;
        start_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = 32'd0;
        src2_i  = 32'd0;
        shamt_i = 5'd0;

        #12;
        checkOutput("reset result_o", 64'(result_o), 64'd0);
        checkOutput("reset hi_o",     64'(hi_o),     64'd0);
        checkOutput("reset zero_o",   64'(zero_o),   64'd1);
        checkOutput("reset ovf_o",    64'(ovf_o),    64'd0);
        checkOutput("reset busy_o",   64'(busy_o),   64'd0);
        checkOutput("reset done_o",   64'(done_o),   64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // isolated add, then a back-to-back stream of single-cycle ops
        applyStimulus(4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 32'd12, 32'd0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b1);
        applyStimulus(4'b0110, 32'd3, 32'd3, 5'd0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 32'd31, 32'h80000000, 5'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 32'd0, 32'h00001234, 5'd0, 1'b1, 32'h12340000, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1'b1, 32'h0000F000, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1'b1, 32'h0000FFF0, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 32'd0, 32'd1, 5'd31, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b1000, 32'd9, 32'd9, 5'd0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(4'b0110, 32'h80000000, 32'd1, 5'd0, 1'b1, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b1);
        idle(3);
        checkOutput("hold result_o", 64'(result_o), 64'h7FFFFFFF);
        checkOutput("hold ovf_o",    64'(ovf_o),    64'd1);

        // signed multiply -3 * 7; ovf_o cleared by mult
        doneBefore = doneCount;
        runMul(32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
        idle(3);
        checkOutput("mult -3*7 done count", 64'(doneCount - doneBefore), 64'd1);

        // single-cycle op leaves hi_o untouched
        applyStimulus(4'b0010, 32'd1, 32'd1, 5'd0, 1'b1, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
        idle(2);

        // start held and operands scrambled during MUL
        doneBefore = doneCount;
        runMul(32'h00010000, 32'h00010000, 1'b1, 1'b1, 32'd0, 32'd1, 1'b1);
        idle(3);
        checkOutput("mult held-start done count", 64'(doneCount - doneBefore), 64'd1);

        // reset pulsed at edge k+10 of a multiply
        doneBefore = doneCount;
        applyStimulus(4'b0011, 32'd5, 32'd6, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        checkOutput("busy before abort", 64'(busy_o), 64'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("abort result_o", 64'(result_o), 64'd0);
        checkOutput("abort hi_o",     64'(hi_o),     64'd0);
        checkOutput("abort zero_o",   64'(zero_o),   64'd1);
        checkOutput("abort ovf_o",    64'(ovf_o),    64'd0);
        checkOutput("abort busy_o",   64'(busy_o),   64'd0);
        checkOutput("abort done_o",   64'(done_o),   64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (30) @(negedge clk_i);
        checkOutput("abort no done", 64'(doneCount - doneBefore), 64'd0);
        applyStimulus(4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 32'd12, 32'd0, 1'b0, 1'b0);
        idle(3);

        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start_i  in  1  request; sampled only in IDLE.
REQ-004 SHALL have ports: ctrl_i  in  4  operation code from ALU_Ctrl.
REQ-005 SHALL have ports: src1_i  in  32  operand A (rs).
REQ-006 SHALL have ports: src2_i  in  32  operand B (rt/immediate).
REQ-007 SHALL have ports: shamt_i  in  5  shift amount for sll.
REQ-008 SHALL have ports: result_o  out  32  registered result / product low word.
REQ-009 SHALL have ports: hi_o  out  32  product high word.
REQ-010 SHALL have ports: zero_o  out  1  high when result_o == 0.
REQ-011 SHALL have ports: ovf_o  out  1  signed overflow of last add/sub.
REQ-012 SHALL have ports: busy_o  out  1  multiply in progress.
REQ-013 SHALL have ports: done_o  out  1  one-cycle result-valid pulse.

Function
REQ-014 Opcode map SHALL be: 0000 and; 0001 or; 0010 add; 0110 sub; 0111 slt (signed, result 1/0); 0101 sll (src2 << shamt_i); 1111 srlv (src2 >> src1[4:0], logical); 0100 lui (src2 << 16); 0011 mult.
REQ-015 Any other opcode SHALL complete as single-cycle with result_o = 0, ovf_o = 0.
REQ-016 States SHALL be IDLE and MUL only.
REQ-017 Accept: start_i = 1 at rising edge while in IDLE; start_i in MUL SHALL be ignored, not queued.
REQ-018 Single-cycle ops: at the accept edge result_o, zero_o, ovf_o SHALL update and done_o SHALL be 1 for the following cycle; state stays IDLE.
REQ-019 Back-to-back single-cycle starts SHALL be accepted every cycle, done_o high each cycle.
REQ-020 mult: accept edge k latches operands, enters MUL, busy_o = 1 from edge k.
REQ-021 mult SHALL be iterative shift-add, one bit per edge, edges k+1..k+32, signed 32x32 -> 64 product.
REQ-022 At edge k+32: {hi_o, result_o} = product, busy_o = 0, done_o = 1 for one cycle, return to IDLE.
REQ-023 A start_i at edge k+32 SHALL be ignored; next accept earliest at edge k+33.
REQ-024 Operand changes on src1_i/src2_i during MUL SHALL NOT affect the product.
REQ-025 hi_o SHALL change only on mult completion; single-cycle ops leave it unchanged.
REQ-026 ovf_o SHALL be computed for add/sub only (operand signs equal/differ vs result sign); 0 for all others including mult.
REQ-027 zero_o SHALL reflect result_o (low word) after every completion.
REQ-028 result_o, zero_o, ovf_o SHALL hold between completions.

Reset
REQ-029 rst_i low SHALL immediately force IDLE, result_o = 0, hi_o = 0, zero_o = 1, ovf_o = 0, busy_o = 0, done_o = 0, iteration counter = 0.
REQ-030 Reset during MUL SHALL abort without a done_o pulse; first accept possible at first rising edge after rst_i returns high.

Verification
REQ-031 add src1=5, src2=7 -> next cycle result_o=12, zero_o=0, ovf_o=0, done_o pulse 1 cycle.
REQ-032 add 0x7FFFFFFF+1 -> result_o=0x80000000, ovf_o=1; sub 3-3 -> result_o=0, zero_o=1.
REQ-033 slt src1=0xFFFFFFFF, src2=1 -> result_o=1; srlv src2=0x80000000, src1=31 -> result_o=1; lui src2=0x1234 -> 0x12340000.
REQ-034 mult src1=-3, src2=7 -> busy_o 32 cycles, then result_o=0xFFFFFFEB, hi_o=0xFFFFFFFF, done_o single pulse at edge k+32.
REQ-035 mult 0x10000*0x10000 with start_i held high and operands changed mid-MUL -> result_o=0, hi_o=1, zero_o=1, exactly one done_o.
REQ-036 rst_i pulsed low at edge k+10 of a mult -> all outputs at reset values, no done_o, fresh add accepted after release.
